inst_mem_bank: RTL and testbench

Parametrised, synchronous instruction memory for the RV32V fetch stage. It accepts fetch requests on a valid/ready handshake and returns the instruction word one cycle later through a single-entry response register that holds under back-pressure. A load port lets the bench or boot logic write the program at run time. Out-of-range or misaligned fetches return a NOP flagged as a fault.

---
 rtl/inst_mem_bank_if.sv | 28 ++
 rtl/inst_mem_bank.sv | 133 +++++++++++++
 tb/tb_inst_mem_bank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_bank_if.sv
// Fetch request, fetch response and program-load handshake bundle for inst_mem_bank.
interface inst_mem_bank_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] PC;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] Instruction_Code;
    logic              fetch_fault;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              busy;

    modport master (
        output req_valid, PC, rsp_ready, ld_valid, ld_addr, ld_data,
        input  req_ready, rsp_valid, Instruction_Code, fetch_fault, ld_ready, busy
    );

    modport slave (
        input  req_valid, PC, rsp_ready, ld_valid, ld_addr, ld_data,
        output req_ready, rsp_valid, Instruction_Code, fetch_fault, ld_ready, busy
    );
endinterface

// File: rtl/inst_mem_bank.sv
// Instruction memory with valid/ready fetch, one-entry response register and a load port.
// Define INST_MEM_BOOT_CLEAR_EN to fill every word with NOP_WORD after each reset.
module inst_mem_bank #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       BYTE_ADDR = 1,
    parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(32'h0000_0013)
) (
    input  logic           clk,
    input  logic           reset,
    inst_mem_bank_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SHIFT = (BYTE_ADDR != 0) ? 2 : 0;

    logic [DATA_W-1:0] mem [DEPTH];

    // Range test on the full-width word address so high bits never alias into range.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word;
        word = addr >> SHIFT;
        return (word < ADDR_W'(DEPTH)) && ((BYTE_ADDR == 0) || (addr[1:0] == 2'b00));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'(addr >> SHIFT);
    endfunction

    logic             run_c;
    logic             clr_we_c;
    logic [IDX_W-1:0] clr_idx_c;

`ifdef INST_MEM_BOOT_CLEAR_EN
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + IDX_W'(1);
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign run_c     = (state_q == ST_RUN);
    assign clr_we_c  = (state_q == ST_CLEAR);
    assign clr_idx_c = clr_cnt_q;
`else
    assign run_c     = 1'b1;
    assign clr_we_c  = 1'b0;
    assign clr_idx_c = '0;
`endif

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_fault_q, rsp_fault_d;

    logic             req_ready_c, req_fire_c, ld_fire_c;
    logic             req_ok_c, ld_ok_c;
    logic [IDX_W-1:0] req_idx_c, ld_idx_c;

    // Loads take priority; a fetch also waits while an unpopped response is held.
    assign req_ready_c = run_c && !bus.ld_valid && (!rsp_valid_q || bus.rsp_ready);
    assign req_fire_c  = bus.req_valid && req_ready_c;
    assign ld_fire_c   = bus.ld_valid && run_c;
    assign req_ok_c    = addr_ok(bus.PC);
    assign req_idx_c   = addr_idx(bus.PC);
    assign ld_ok_c     = addr_ok(bus.ld_addr);
    assign ld_idx_c    = addr_idx(bus.ld_addr);

    // Array is not reset; boot clear (if built) owns the write port until RUN.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_idx_c] <= NOP_WORD;
        end else if (ld_fire_c && ld_ok_c) begin
            mem[ld_idx_c] <= bus.ld_data;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        if (req_fire_c) begin
            rsp_valid_d = 1'b1;
            if (req_ok_c) begin
                rsp_data_d  = mem[req_idx_c];
                rsp_fault_d = 1'b0;
            end else begin
                rsp_data_d  = NOP_WORD;
                rsp_fault_d = 1'b1;
            end
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign bus.req_ready        = req_ready_c;
    assign bus.ld_ready         = run_c;
    assign bus.busy             = !run_c;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.Instruction_Code = rsp_data_q;
    assign bus.fetch_fault      = rsp_fault_q;
endmodule

// File: tb/tb_inst_mem_bank.sv
// Self-checking bench for inst_mem_bank (DEPTH=16, byte addressing), with or without boot clear.
module tb_inst_mem_bank;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef INST_MEM_BOOT_CLEAR_EN
    localparam logic BOOT_CLR = 1'b1;
`else
    localparam logic BOOT_CLR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    inst_mem_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    inst_mem_bank #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYTE_ADDR(1), .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference: word array plus the single response slot it implies.
    logic [31:0] mmem [DEPTH];
    logic        m_valid;
    logic [31:0] m_code;
    logic        m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic addr_good(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH));
    endfunction

    // One clock: drive at negedge, check ready, then check the response after the edge.
    task automatic cycle(input logic rv, input logic [31:0] pc, input logic rr,
                         input logic lv, input logic [31:0] la, input logic [31:0] ld,
                         input string tag);
        logic exp_rr, facc;
        @(negedge clk);
        bus.req_valid = rv; bus.PC = pc; bus.rsp_ready = rr;
        bus.ld_valid  = lv; bus.ld_addr = la; bus.ld_data = ld;
        #1;
        exp_rr = !lv && (!m_valid || rr);
        chk({tag, ":req_ready"}, 32'(bus.req_ready), 32'(exp_rr));
        chk({tag, ":ld_ready"},  32'(bus.ld_ready),  32'(1'b1));
        facc = rv && exp_rr;
        @(posedge clk);
        #1;
        if (lv && addr_good(la)) mmem[la[IDX_W+1:2]] = ld;
        if (facc) begin
            m_valid = 1'b1;
            if (addr_good(pc)) begin
                m_code  = mmem[pc[IDX_W+1:2]];
                m_fault = 1'b0;
            end else begin
                m_code  = NOP;
                m_fault = 1'b1;
            end
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        chk({tag, ":rsp_valid"}, 32'(bus.rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk({tag, ":code"},  bus.Instruction_Code, m_code);
            chk({tag, ":fault"}, 32'(bus.fetch_fault), 32'(m_fault));
        end
    endtask

    task automatic do_reset(input string tag);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.ld_valid = 1'b0; bus.rsp_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk({tag, ":rst_rsp_valid"}, 32'(bus.rsp_valid), 32'(1'b0));
        chk({tag, ":rst_code"},      bus.Instruction_Code, 32'h0);
        chk({tag, ":rst_fault"},     32'(bus.fetch_fault), 32'(1'b0));
        chk({tag, ":rst_busy"},      32'(bus.busy), 32'(BOOT_CLR));
        chk({tag, ":rst_ld_ready"},  32'(bus.ld_ready), 32'(!BOOT_CLR));
        chk({tag, ":rst_req_ready"}, 32'(bus.req_ready), 32'(!BOOT_CLR));
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
`ifdef INST_MEM_BOOT_CLEAR_EN
        for (int i = 0; i < int'(DEPTH); i++) mmem[i] = NOP;
        bus.req_valid = 1'b1; bus.PC = 32'h0;
        n = 0;
        #1;
        while (bus.busy && n < 4 * int'(DEPTH)) begin
            chk({tag, ":clr_req_ready"}, 32'(bus.req_ready), 32'(1'b0));
            @(posedge clk);
            #1;
            n++;
        end
        bus.req_valid = 1'b0;
        chk({tag, ":busy_cycles"}, 32'(n), 32'(DEPTH));
        chk({tag, ":clr_no_rsp"}, 32'(bus.rsp_valid), 32'(1'b0));
`else
        n = 0;
`endif
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        rr;
        logic        lv;
        logic [31:0] la;
        logic [31:0] ld;
        logic        ev;
        logic [31:0] ec;
        logic        ef;
    } vec_t;

    vec_t tbl [12];

    task automatic random_phase(input int ncyc, input string tag);
        logic [31:0] pc, la;
        for (int i = 0; i < ncyc; i++) begin
            case ($urandom_range(0, 7))
                0:       pc = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
                1:       pc = $urandom;
                default: pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
            endcase
            la = ($urandom_range(0, 5) == 0) ? $urandom : (32'($urandom_range(0, DEPTH - 1)) << 2);
            cycle(($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 5) == 0), la, $urandom, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.PC = '0; bus.rsp_ready = 1'b0;
        bus.ld_valid  = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        m_valid = 1'b0; m_code = '0; m_fault = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mmem[i] = NOP;

        do_reset("boot");
`ifdef INST_MEM_BOOT_CLEAR_EN
        cycle(1'b1, 32'h3C, 1'b1, 1'b0, 32'h0, 32'h0, "boot_fetch");
        chk("boot_fetch_nop", bus.Instruction_Code, 32'h0000_0013);
        chk("boot_fetch_nofault", 32'(bus.fetch_fault), 32'(1'b0));
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, "boot_drain");
`endif
        for (int i = 0; i < int'(DEPTH); i++)
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'(i) << 2, 32'hA500_0000 | 32'(i), "preload");

        tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h0090_0093, 1'b0, 32'h0,         1'b0};
        tbl[1]  = '{1'b1, 32'h8,        1'b1, 1'b0, 32'h0,        32'h0,         1'b1, 32'h0090_0093, 1'b0};
        tbl[2]  = '{1'b1, 32'h6,        1'b1, 1'b0, 32'h0,        32'h0,         1'b1, 32'h0000_0013, 1'b1};
        tbl[3]  = '{1'b1, 32'h40,       1'b1, 1'b0, 32'h0,        32'h0,         1'b1, 32'h0000_0013, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h400,      32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
        tbl[5]  = '{1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,         1'b1, 32'hA500_0000, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_0004, 32'hCAFE_F00D, 1'b0, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 32'h4,        1'b1, 1'b0, 32'h0,        32'h0,         1'b1, 32'hA500_0001, 1'b0};
        tbl[8]  = '{1'b1, 32'h8000_0008, 1'b1, 1'b0, 32'h0,       32'h0,         1'b1, 32'h0000_0013, 1'b1};
        tbl[9]  = '{1'b1, 32'h3C,       1'b1, 1'b0, 32'h0,        32'h0,         1'b1, 32'hA500_000F, 1'b0};
        tbl[10] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       32'h0,         1'b1, 32'h0000_0013, 1'b1};
        tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         1'b0};

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rv, tbl[i].pc, tbl[i].rr, tbl[i].lv, tbl[i].la, tbl[i].ld, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_code", i),  bus.Instruction_Code, tbl[i].ec);
                chk($sformatf("tbl%0d_fault", i), 32'(bus.fetch_fault), 32'(tbl[i].ef));
            end
        end

        // Back-pressure: response held, fetch stalled, then back-to-back drain in order.
        cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 32'h0, "bp_first");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, "bp_hold");
            chk("bp_hold_code", bus.Instruction_Code, 32'hA500_0004);
        end
        cycle(1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 32'h0, "bp_go0");
        chk("bp_go0_code", bus.Instruction_Code, 32'hA500_0005);
        cycle(1'b1, 32'h18, 1'b1, 1'b0, 32'h0, 32'h0, "bp_go1");
        chk("bp_go1_code", bus.Instruction_Code, 32'hA500_0006);
        cycle(1'b1, 32'h1C, 1'b1, 1'b0, 32'h0, 32'h0, "bp_go2");
        chk("bp_go2_code", bus.Instruction_Code, 32'hA500_0007);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, "bp_drain");

        // Load and fetch together: load wins, fetch retried next cycle sees the new word.
        cycle(1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'h1234_5678, "col_ld");
        chk("col_stall", 32'(bus.rsp_valid), 32'(1'b0));
        cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 32'h0, "col_fetch");
        chk("col_code", bus.Instruction_Code, 32'h1234_5678);

        random_phase(400, "rnd");

        // Reset in the middle of a held response.
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "mid_fill");
        do_reset("mid");
        cycle(1'b1, 32'h3C, 1'b1, 1'b0, 32'h0, 32'h0, "post_rst_fetch");
        random_phase(150, "rnd2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
